// File: rtl/i2c_slave_pkg.sv
// Shared types for the I2C slave endpoint: transfer direction, FSM states
// and the majority vote used by the optional line filter.
package i2c_slave_pkg;

  localparam int unsigned I2C_BYTE_W = 8;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP,
    IGNORE
  } i2c_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_slave_if_if.sv
// Local-side handshake between the I2C slave endpoint and its user logic.
interface i2c_slave_if_if;
  import i2c_slave_pkg::*;

  logic                  xfer_start;
  logic                  xfer_op;
  logic                  wr_valid;
  logic [I2C_BYTE_W-1:0] wr_data;
  logic                  rd_req;
  logic [I2C_BYTE_W-1:0] rd_data;
  logic                  xfer_done;
  logic [I2C_BYTE_W-1:0] byte_cnt;

  modport slave (
    output xfer_start, xfer_op, wr_valid, wr_data, rd_req, xfer_done, byte_cnt,
    input  rd_data
  );

  modport master (
    input  xfer_start, xfer_op, wr_valid, wr_data, rd_req, xfer_done, byte_cnt,
    output rd_data
  );

endinterface

// File: rtl/i2c_slave_if_line_sync.sv
// One I2C line: 2-FF synchronizer, optional 3-sample majority filter
// (I2C_SLAVE_GLITCH_FILTER_EN), and rise/fall detection on the clean level.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       clean;

  // Reset to the idle-high bus level so no edge is reported out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[0], line_i};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       maj_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '1;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      maj_q  <= i2c_slave_pkg::maj3(sync_q[1], hist_q[0], hist_q[1]);
    end
  end

  assign clean = maj_q;
`else
  assign clean = sync_q[1];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b1;
    else       prev_q <= clean;
  end

  assign level_o = clean;
  assign rise_o  = clean & ~prev_q;
  assign fall_o  = ~clean & prev_q;

endmodule

// File: rtl/i2c_slave_if.sv
// I2C slave endpoint: address match/ACK, write receive, read transmit.
// Optional input glitch filter enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_if
  import i2c_slave_pkg::*;
#(
  parameter int unsigned I2C_ADDR_WIDTH  = 7,
  parameter int unsigned I2C_DATA_WIDTH  = 8,
  parameter logic [7:0]  I2C_DEVICE_ADDR = 8'h22
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           scl_i,
  input  logic           sda_i,
  output logic           sda_o,
  i2c_slave_if_if.slave  host
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_sync u_scl (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync u_sda (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_t                state_q;
  logic [I2C_DATA_WIDTH-1:0] shift_q;
  logic [3:0]                bit_cnt_q;
  logic                      sda_q;
  i2c_op_t                   op_q;
  logic [7:0]                wr_data_q;
  logic [7:0]                byte_cnt_q;
  logic                      matched_q;
  logic                      loaded_q;
  logic                      rd_dly_q;
  logic                      start_q, wr_valid_q, rd_req_q, done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sda_q      <= 1'b1;
      op_q       <= I2C_WRITE;
      wr_data_q  <= '0;
      byte_cnt_q <= '0;
      matched_q  <= 1'b0;
      loaded_q   <= 1'b0;
      rd_dly_q   <= 1'b0;
      start_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      done_q     <= 1'b0;
      rd_dly_q   <= rd_req_q;

      if (start_det || stop_det) begin
        done_q    <= matched_q;
        matched_q <= 1'b0;
        sda_q     <= 1'b1;
        bit_cnt_q <= '0;
        state_q   <= start_det ? ADDR : IDLE;
      end else begin
        unique case (state_q)
          IDLE: ;

          ADDR: begin
            // Cleared here rather than at START so byte_cnt stays valid
            // during the xfer_done pulse of a repeated START.
            byte_cnt_q <= '0;
            if (scl_rise) begin
              shift_q   <= {shift_q[I2C_DATA_WIDTH-2:0], sda_lvl};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'(I2C_DATA_WIDTH - 1)) begin
                bit_cnt_q <= '0;
                if (shift_q[I2C_ADDR_WIDTH-1:0] == I2C_DEVICE_ADDR[I2C_ADDR_WIDTH-1:0]) begin
                  matched_q <= 1'b1;
                  op_q      <= i2c_op_t'(sda_lvl);
                  state_q   <= ADDR_ACK;
                end else begin
                  state_q   <= IGNORE;
                end
              end
            end
          end

          // First SCL fall asserts the ACK, the second releases it.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (sda_q) begin
                sda_q <= 1'b0;
              end else begin
                sda_q     <= 1'b1;
                start_q   <= 1'b1;
                bit_cnt_q <= '0;
                if (op_q == I2C_READ) begin
                  rd_req_q <= 1'b1;
                  loaded_q <= 1'b0;
                  state_q  <= RD_DATA;
                end else begin
                  state_q  <= WR_DATA;
                end
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[I2C_DATA_WIDTH-2:0], sda_lvl};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'(I2C_DATA_WIDTH - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= WR_ACK;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (sda_q) begin
                sda_q <= 1'b0;
              end else begin
                sda_q      <= 1'b1;
                wr_valid_q <= 1'b1;
                wr_data_q  <= shift_q;
                byte_cnt_q <= (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 8'd1;
                state_q    <= WR_DATA;
              end
            end
          end

          // Load two cycles after rd_req, then put the MSB out as soon as
          // SCL is low; later bits follow each SCL fall.
          RD_DATA: begin
            if (rd_dly_q) begin
              shift_q  <= host.rd_data;
              loaded_q <= 1'b1;
            end else if (loaded_q && bit_cnt_q == '0 && !scl_lvl) begin
              sda_q     <= shift_q[I2C_DATA_WIDTH-1];
              shift_q   <= {shift_q[I2C_DATA_WIDTH-2:0], 1'b0};
              bit_cnt_q <= 4'd1;
            end else if (bit_cnt_q != '0 && scl_fall) begin
              if (bit_cnt_q == 4'(I2C_DATA_WIDTH)) begin
                sda_q   <= 1'b1;
                state_q <= RD_ACK;
              end else begin
                sda_q     <= shift_q[I2C_DATA_WIDTH-1];
                shift_q   <= {shift_q[I2C_DATA_WIDTH-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              byte_cnt_q <= (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 8'd1;
              if (!sda_lvl) begin
                rd_req_q  <= 1'b1;
                loaded_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= RD_DATA;
              end else begin
                state_q   <= WAIT_STOP;
              end
            end
          end

          WAIT_STOP: ;
          IGNORE:    ;
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_o           = sda_q;
  assign host.xfer_start = start_q;
  assign host.xfer_op    = op_q;
  assign host.wr_valid   = wr_valid_q;
  assign host.wr_data    = wr_data_q;
  assign host.rd_req     = rd_req_q;
  assign host.xfer_done  = done_q;
  assign host.byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_i2c_slave_if.sv
// Directed bench for i2c_slave_if: bit-banged I2C master plus pulse monitors.
module tb_i2c_slave_if;
  import i2c_slave_pkg::*;

  localparam int unsigned H = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_o;
  logic sda_bus;

  always #5 clk = ~clk;
  assign sda_bus = sda_m & sda_o;

  i2c_slave_if_if host ();

  logic [7:0] rd_bytes [0:15];
  int n_start = 0, n_wr = 0, n_rd = 0, n_done = 0, n_sda_low = 0;
  logic       last_op = 1'b0;
  logic [7:0] last_wr = '0;
  logic [7:0] last_done_cnt = '0;
  int checks = 0, errors = 0;

  assign host.rd_data = rd_bytes[(n_rd + 15) % 16];

  i2c_slave_if #(
    .I2C_ADDR_WIDTH (7),
    .I2C_DATA_WIDTH (8),
    .I2C_DEVICE_ADDR(8'h22)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .scl_i(scl_m),
    .sda_i(sda_bus),
    .sda_o(sda_o),
    .host (host)
  );

  always @(negedge clk) begin
    if (host.xfer_start) begin n_start++; last_op = host.xfer_op; end
    if (host.wr_valid)   begin n_wr++;    last_wr = host.wr_data; end
    if (host.rd_req)     n_rd++;
    if (host.xfer_done)  begin n_done++;  last_done_cnt = host.byte_cnt; end
    if (!sda_o)          n_sda_low++;
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(H/2);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b0; wait_clk(H/2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(H/2);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(H/2);
    scl_m = 1'b1; wait_clk(H);
    scl_m = 1'b0; wait_clk(H/2);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(H/2);
    scl_m = 1'b1; wait_clk(H/2);
    b = sda_bus;  wait_clk(H/2);
    scl_m = 1'b0; wait_clk(H/2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
    write_bit(ack);
  endtask

  task automatic test_reset();
    wait_clk(2);
    checks++; if (sda_o !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda_o); end
    checks++; if (host.xfer_start !== 1'b0) begin errors++; $display("FAIL reset_xfer_start: got %b want 0", host.xfer_start); end
    checks++; if (host.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", host.wr_valid); end
    checks++; if (host.rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", host.rd_req); end
    checks++; if (host.xfer_done !== 1'b0) begin errors++; $display("FAIL reset_xfer_done: got %b want 0", host.xfer_done); end
    checks++; if (host.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", host.wr_data); end
    checks++; if (host.xfer_op !== 1'b0) begin errors++; $display("FAIL reset_xfer_op: got %b want 0", host.xfer_op); end
    checks++; if (host.byte_cnt !== 8'h00) begin errors++; $display("FAIL reset_byte_cnt: got %h want 00", host.byte_cnt); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    rst = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_write();
    int s0, w0, d0;
    logic a1, a2;
    s0 = n_start; w0 = n_wr; d0 = n_done;
    i2c_start();
    write_byte(8'h44, a1);
    write_byte(8'h78, a2);
    i2c_stop();
    wait_clk(20);
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", a1); end
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL wr_data_ack: got %b want 0", a2); end
    checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL wr_xfer_start: got %0d want 1", n_start - s0); end
    checks++; if (last_op !== 1'b0) begin errors++; $display("FAIL wr_xfer_op: got %b want 0", last_op); end
    checks++; if (n_wr - w0 != 1) begin errors++; $display("FAIL wr_valid_count: got %0d want 1", n_wr - w0); end
    checks++; if (last_wr !== 8'h78) begin errors++; $display("FAIL wr_data: got %h want 78", last_wr); end
    checks++; if (host.wr_data !== 8'h78) begin errors++; $display("FAIL wr_data_held: got %h want 78", host.wr_data); end
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL wr_xfer_done: got %0d want 1", n_done - d0); end
    checks++; if (last_done_cnt !== 8'd1) begin errors++; $display("FAIL wr_byte_cnt: got %0d want 1", last_done_cnt); end
  endtask

  task automatic test_ignore();
    int s0, w0, d0, l0;
    logic a1, a2;
    s0 = n_start; w0 = n_wr; d0 = n_done; l0 = n_sda_low;
    i2c_start();
    write_byte(8'h46, a1);
    write_byte(8'h12, a2);
    i2c_stop();
    wait_clk(20);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL ign_addr_nack: got %b want 1", a1); end
    checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL ign_data_nack: got %b want 1", a2); end
    checks++; if (n_start != s0 || n_wr != w0 || n_done != d0) begin
      errors++; $display("FAIL ign_pulses: got start/wr/done %0d/%0d/%0d want 0/0/0", n_start - s0, n_wr - w0, n_done - d0);
    end
    checks++; if (n_sda_low != l0) begin errors++; $display("FAIL ign_sda_silent: got %0d low cycles want 0", n_sda_low - l0); end
  endtask

  task automatic test_read();
    int s0, r0, d0;
    logic a1;
    logic [7:0] b1, b2;
    s0 = n_start; r0 = n_rd; d0 = n_done;
    rd_bytes[n_rd % 16]       = 8'hA5;
    rd_bytes[(n_rd + 1) % 16] = 8'h3C;
    i2c_start();
    write_byte(8'h45, a1);
    read_byte(b1, 1'b0);
    read_byte(b2, 1'b1);
    i2c_stop();
    wait_clk(20);
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b want 0", a1); end
    checks++; if (last_op !== 1'b1) begin errors++; $display("FAIL rd_xfer_op: got %b want 1", last_op); end
    checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL rd_xfer_start: got %0d want 1", n_start - s0); end
    checks++; if (b1 !== 8'hA5) begin errors++; $display("FAIL rd_byte0: got %h want a5", b1); end
    checks++; if (b2 !== 8'h3C) begin errors++; $display("FAIL rd_byte1: got %h want 3c", b2); end
    checks++; if (n_rd - r0 != 2) begin errors++; $display("FAIL rd_req_count: got %0d want 2", n_rd - r0); end
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL rd_xfer_done: got %0d want 1", n_done - d0); end
    checks++; if (last_done_cnt !== 8'd2) begin errors++; $display("FAIL rd_byte_cnt: got %0d want 2", last_done_cnt); end
  endtask

  task automatic test_back_to_back();
    int s0, w0, d0;
    logic a1, a2, a3;
    logic [7:0] b1;
    s0 = n_start; w0 = n_wr; d0 = n_done;
    rd_bytes[n_rd % 16] = 8'h5A;
    i2c_start();
    write_byte(8'h44, a1);
    write_byte(8'h11, a2);
    i2c_start();
    write_byte(8'h45, a3);
    wait_clk(1);
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL rs_done_count: got %0d want 1", n_done - d0); end
    checks++; if (last_done_cnt !== 8'd1) begin errors++; $display("FAIL rs_done_byte_cnt: got %0d want 1", last_done_cnt); end
    checks++; if (n_start - s0 != 2) begin errors++; $display("FAIL rs_start_count: got %0d want 2", n_start - s0); end
    checks++; if (last_op !== 1'b1) begin errors++; $display("FAIL rs_xfer_op: got %b want 1", last_op); end
    checks++; if (last_wr !== 8'h11 || n_wr - w0 != 1) begin
      errors++; $display("FAIL rs_wr: got %h x%0d want 11 x1", last_wr, n_wr - w0);
    end
    read_byte(b1, 1'b1);
    i2c_stop();
    wait_clk(20);
    checks++; if (b1 !== 8'h5A) begin errors++; $display("FAIL rs_rd_byte: got %h want 5a", b1); end
    checks++; if (n_done - d0 != 2 || last_done_cnt !== 8'd1) begin
      errors++; $display("FAIL rs_final_done: got %0d cnt %0d want 2 cnt 1", n_done - d0, last_done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int s0, w0, d0;
    logic a1, a2;
    logic [7:0] addr;
    s0 = n_start; d0 = n_done;
    addr = 8'h44;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(addr[i]);
    wait_clk(3);
    checks++; if (sda_o !== 1'b0) begin errors++; $display("FAIL rm_ack_held: got %b want 0", sda_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sda_o !== 1'b1) begin errors++; $display("FAIL rm_sda_async: got %b want 1", sda_o); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rm_state: got %0d want IDLE", dut.state_q); end
    wait_clk(3);
    rst = 1'b0;
    i2c_stop();
    wait_clk(10);
    checks++; if (n_start != s0 || n_done != d0) begin
      errors++; $display("FAIL rm_no_pulses: got start/done %0d/%0d want 0/0", n_start - s0, n_done - d0);
    end
    w0 = n_wr;
    i2c_start();
    write_byte(8'h44, a1);
    write_byte(8'h9C, a2);
    i2c_stop();
    wait_clk(20);
    checks++; if (n_wr - w0 != 1 || last_wr !== 8'h9C) begin
      errors++; $display("FAIL rm_recover: got %h x%0d want 9c x1", last_wr, n_wr - w0);
    end
  endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic write_bit_glitch(input logic b);
    sda_m = b;    wait_clk(H/2);
    scl_m = 1'b1; wait_clk(H/2);
    scl_m = 1'b0; wait_clk(1);
    scl_m = 1'b1; wait_clk(H/2 - 1);
    scl_m = 1'b0; wait_clk(H/2);
  endtask

  task automatic test_glitch();
    int w0;
    logic a1, a2;
    logic [7:0] d;
    w0 = n_wr;
    d = 8'hB6;
    i2c_start();
    write_byte(8'h44, a1);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) write_bit_glitch(d[i]);
      else        write_bit(d[i]);
    end
    read_bit(a2);
    i2c_stop();
    wait_clk(20);
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL gl_ack: got %b want 0", a2); end
    checks++; if (n_wr - w0 != 1 || last_wr !== 8'hB6) begin
      errors++; $display("FAIL gl_data: got %h x%0d want b6 x1", last_wr, n_wr - w0);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rd_bytes[i] = 8'h00;
    test_reset();
    test_write();
    test_ignore();
    test_read();
    test_back_to_back();
    test_reset_mid();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
